line_sampler_rx: RTL



---
 rtl/line_sampler_rx.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/line_sampler_rx.sv
`default_nettype none
// ============================================================================
//  Module      : line_sampler_rx
//  Description : Receive stage for a single-bit asynchronous logic line.
//                Synchronises the line into the clk domain, glitch-filters
//                it, flags filtered rising/falling edges, samples the
//                filtered level every DIV cycles and packs WORD_W samples
//                LSB-first into words delivered over valid/ready with a
//                sticky overflow flag for dropped words.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk          in   rising-edge clock
//    rst_n        in   asynchronous active-low reset
//    en           in   sampling enable; low stops and clears word assembly
//    line_in      in   asynchronous line from upstream driver
//    word_data    out  assembled word, bit k = k-th sample of the word
//    word_valid   out  word_data holds an unconsumed word
//    word_ready   in   consumer takes the word this cycle when word_valid=1
//    rise_pulse   out  one-cycle pulse on filtered 0->1
//    fall_pulse   out  one-cycle pulse on filtered 1->0
//    overflow     out  sticky: a completed word was dropped
//    clr_overflow in   synchronous clear of overflow (a same-cycle drop wins)
// ============================================================================
module line_sampler_rx #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILT_LEN    = 4,
    parameter int unsigned DIV         = 8,
    parameter int unsigned WORD_W      = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              line_in,
    output logic [WORD_W-1:0] word_data,
    output logic              word_valid,
    input  logic              word_ready,
    output logic              rise_pulse,
    output logic              fall_pulse,
    output logic              overflow,
    input  logic              clr_overflow
);

    localparam int unsigned c_FILT_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
    localparam int unsigned c_DIV_W  = $clog2(DIV);
    localparam int unsigned c_BIT_W  = $clog2(WORD_W);

    localparam logic [c_FILT_W-1:0] c_FILT_LAST = c_FILT_W'(FILT_LEN - 1);
    localparam logic [c_DIV_W-1:0]  c_DIV_LAST  = c_DIV_W'(DIV - 1);
    localparam logic [c_BIT_W-1:0]  c_BIT_LAST  = c_BIT_W'(WORD_W - 1);

    // ------------------------------------------------------------------
    // Synchroniser and glitch filter
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_sync;
    logic [c_FILT_W-1:0]    r_filt_cnt;
    logic                   r_filt_q;
    logic                   r_filt_d;
    logic                   w_sync_out;

    assign w_sync_out = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync     <= '0;
            r_filt_cnt <= '0;
            r_filt_q   <= 1'b0;
            r_filt_d   <= 1'b0;
        end else begin
            r_sync   <= {r_sync[SYNC_STAGES-2:0], line_in};
            r_filt_d <= r_filt_q;
            // The filtered level only moves after FILT_LEN consecutive
            // cycles of disagreement; any agreeing cycle restarts the count.
            if (w_sync_out != r_filt_q) begin
                if (r_filt_cnt == c_FILT_LAST) begin
                    r_filt_q   <= w_sync_out;
                    r_filt_cnt <= '0;
                end else begin
                    r_filt_cnt <= r_filt_cnt + 1'b1;
                end
            end else begin
                r_filt_cnt <= '0;
            end
        end
    end

    // Both operands are flops, so the pulses carry no input-to-output path.
    assign rise_pulse = r_filt_q & ~r_filt_d;
    assign fall_pulse = ~r_filt_q & r_filt_d;

    // ------------------------------------------------------------------
    // Sample tick generation and word assembly
    // ------------------------------------------------------------------
    logic [c_DIV_W-1:0] r_div_cnt;
    logic [c_BIT_W-1:0] r_bit_cnt;
    logic [WORD_W-1:0]  r_shreg;
    logic               w_tick;
    logic               w_complete;
    logic [WORD_W-1:0]  w_word;

    assign w_tick     = en & (r_div_cnt == c_DIV_LAST);
    assign w_complete = w_tick & (r_bit_cnt == c_BIT_LAST);
    // The completing sample has not reached the shift register yet, so it
    // is merged in here as the MSB of the outgoing word.
    assign w_word     = {r_filt_q, r_shreg[WORD_W-2:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div_cnt <= '0;
            r_bit_cnt <= '0;
            r_shreg   <= '0;
        end else if (!en) begin
            // Dropping enable abandons any partial word.
            r_div_cnt <= '0;
            r_bit_cnt <= '0;
            r_shreg   <= '0;
        end else begin
            r_div_cnt <= (r_div_cnt == c_DIV_LAST) ? '0 : r_div_cnt + 1'b1;
            if (w_tick) begin
                if (r_bit_cnt == c_BIT_LAST) begin
                    r_bit_cnt <= '0;
                    r_shreg   <= '0;
                end else begin
                    r_shreg[r_bit_cnt] <= r_filt_q;
                    r_bit_cnt          <= r_bit_cnt + 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Output register with valid/ready handshake and sticky overflow
    // ------------------------------------------------------------------
    logic w_load;
    logic w_drop;

    // A completion may reuse the slot in the same cycle it is consumed.
    assign w_load = w_complete & (~word_valid | word_ready);
    assign w_drop = w_complete & word_valid & ~word_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_data  <= '0;
            word_valid <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            if (w_load) begin
                word_data  <= w_word;
                word_valid <= 1'b1;
            end else if (word_valid && word_ready) begin
                word_valid <= 1'b0;
            end

            if (w_drop) begin
                overflow <= 1'b1;
            end else if (clr_overflow) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire
